multi_cycle_controller: RTL and testbench
=========================================

Name: multi_cycle_controller

Overview:
Moore-style FSM that sequences the multi-cycle RV32I datapath: shared instruction/data memory, IR/OldPC/A/B/ALUOut/Data registers, one ALU. It covers the same instruction subset as the single-cycle main decoder: R, I-ALU, lw, sw, B, jal, jalr, lui. It drives every mux select and write enable per cycle, waits on a memory ready handshake, and flags illegal opcodes. The ALU decoder (funct3/funct7 -> ALU control) and the branch comparator stay outside; this block emits alu_op and consumes branch_taken.

Parameters:
ILLEGAL_TRAP, 1, 1: an unknown opcode parks the FSM in TRAP until reset; 0: an unknown opcode returns to FETCH and executes as a NOP.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0], stable from the cycle after FETCH completes
mem_ready  in  1  shared memory completes the current access this cycle
branch_taken  in  1  external comparator result for the current B-type instruction
pc_write  out  1  PC register load enable
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  load IR and OldPC
reg_write  out  1  register file write enable
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = A
alu_src_b  out  2  00 = B, 01 = ImmExt, 10 = constant 4
alu_op  out  2  00 = add, 01 = sub/compare, 10 = R funct decode, 11 = I funct decode
imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
illegal  out  1  high while in TRAP
retire  out  1  one-cycle pulse on the last cycle of each instruction
state  out  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. While rst=1 at an edge, the next state is FETCH.
- Outputs are combinational from state, opcode and mem_ready. In the cycle rst is high, all enables (pc_write, mem_write, ir_write, reg_write, retire) are forced to 0.
- Every select not used in a state drives 0; no x values on any output.
- imm_src is decoded from opcode in every state: I for lw/I-ALU/jalr, S for sw, B for B-type, J for jal, U for lui, 000 otherwise.
- pc_write = pc_update | (branch & branch_taken). pc_update and branch are internal per-state terms.
- States and actions (unlisted signals = 0):
  - FETCH: adr_src=0, A=PC, B=4, op=add, result=ALUResult. ir_write=pc_update=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
  - DECODE: A=OldPC, B=Imm, add (target to ALUOut). Next state: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, B->BRANCH, jal->JAL, jalr->JALR, lui->LUI, other->TRAP (or FETCH if ILLEGAL_TRAP=0, no retire).
  - MEMADR: A=A, B=Imm, add. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: result=Data, reg_write=1, retire=1. Next: FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, held every cycle until mem_ready. retire=mem_ready. Next: FETCH on mem_ready.
  - EXECR: A=A, B=B, op=10. Next: ALUWB.
  - EXECI: A=A, B=Imm, op=11. Next: ALUWB.
  - ALUWB: result=ALUOut, reg_write=1, retire=1. Next: FETCH.
  - BRANCH: A=A, B=B, op=01, result=ALUOut, branch=1, retire=1. Next: FETCH.
  - JAL: A=OldPC, B=4, add, result=ALUOut, pc_update=1. Next: ALUWB (writes OldPC+4).
  - JALR: A=A, B=Imm, add, result=ALUResult, pc_update=1. Next: JALRLINK.
  - JALRLINK: A=OldPC, B=4, add, result=ALUResult, reg_write=1, retire=1. Next: FETCH.
  - LUI: result=ImmExt, reg_write=1, retire=1. Next: FETCH.
  - TRAP: illegal=1, all enables 0. Leaves only on rst.
- Latencies with mem_ready always high: R/I/lui/B = 3 to 4 cycles, lw = 5, sw = 4, jal = 4, jalr = 4.
- A reset mid-instruction abandons it; no partial writes occur in the reset cycle.

Decomposition:
- Shared package `riscv_ctrl_pkg`: opcode constants, state encodings (4-bit), result_src/alu_src_a/alu_src_b/alu_op/imm_src encodings.
- Natural sub-module: `imm_src_decoder` (opcode -> imm_src), reusable by the single-cycle core.

Test Plan:
- Reset then lw (0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and result_src=01 in MEMWB; retire pulses once.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 and adr_src=1 for 4 cycles; retire only in the mem_ready cycle; next state FETCH.
- beq (1100011): branch_taken=1 -> pc_write=1 in BRANCH; branch_taken=0 -> pc_write=0; imm_src=010; alu_op=01.
- jalr (1100111) -> pc_write in JALR with result_src=10; reg_write in JALRLINK with alu_src_a=01 and alu_src_b=10.
- Opcode 0000000: ILLEGAL_TRAP=1 -> TRAP, illegal=1, no enables for 10 cycles, rst returns to FETCH. ILLEGAL_TRAP=0 -> back to FETCH, no retire.
- rst asserted in MEMWRITE with mem_ready=0 -> mem_write=0 that cycle; state=FETCH next cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: opcodes, multi-cycle FSM
// states and the datapath mux/ALU select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REG   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RFUNC = 2'b10,
    ALU_IFUNC = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode -> immediate format select; shared by the single- and multi-cycle cores.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMM_I;
      OP_STORE:                   imm_src = IMM_S;
      OP_BRANCH:                  imm_src = IMM_B;
      OP_JAL:                     imm_src = IMM_J;
      OP_LUI:                     imm_src = IMM_U;
      default:                    imm_src = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the multi-cycle RV32I datapath: mux selects, write
// enables, memory handshake and illegal-opcode trapping.
module multi_cycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   pc_update, branch, ir_en, mw_en, rw_en, ret_en;

  imm_src_decoder u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mw_en      = 1'b0;
    rw_en      = 1'b0;
    ret_en     = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
        ir_en      = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH can reuse the ALU to compare.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        rw_en      = 1'b1;
        ret_en     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mw_en   = 1'b1;
        ret_en  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_RFUNC;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_IFUNC;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_en   = 1'b1;
        ret_en  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        ret_en    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_JALRLINK;
      end
      S_JALRLINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        rw_en      = 1'b1;
        ret_en     = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        result_src = RES_IMMEXT;
        rw_en      = 1'b1;
        ret_en     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are suppressed during reset so an abandoned instruction leaves no side effects.
  assign pc_write  = ~rst & (pc_update | (branch & branch_taken));
  assign mem_write = ~rst & mw_en;
  assign ir_write  = ~rst & ir_en;
  assign reg_write = ~rst & rw_en;
  assign retire    = ~rst & ret_en;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized self-checking bench: each instruction is expanded into its
// expected per-cycle step list and compared against two DUTs (trap / no-trap).
module tb_multi_cycle_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, mem_ready, branch_taken;
  logic [6:0] opcode;

  logic t_pcw, t_adr, t_mw, t_irw, t_rw, t_ill, t_ret;
  logic [1:0] t_res, t_a, t_b, t_aop;
  logic [2:0] t_imm;
  logic [3:0] t_st;
  logic n_pcw, n_adr, n_mw, n_irw, n_rw, n_ill, n_ret;
  logic [1:0] n_res, n_a, n_b, n_aop;
  logic [2:0] n_imm;
  logic [3:0] n_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(t_pcw), .adr_src(t_adr),
    .mem_write(t_mw), .ir_write(t_irw), .reg_write(t_rw), .result_src(t_res),
    .alu_src_a(t_a), .alu_src_b(t_b), .alu_op(t_aop), .imm_src(t_imm),
    .illegal(t_ill), .retire(t_ret), .state(t_st)
  );

  multi_cycle_controller #(.ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(n_pcw), .adr_src(n_adr),
    .mem_write(n_mw), .ir_write(n_irw), .reg_write(n_rw), .result_src(n_res),
    .alu_src_a(n_a), .alu_src_b(n_b), .alu_op(n_aop), .imm_src(n_imm),
    .illegal(n_ill), .retire(n_ret), .state(n_st)
  );

  wire [21:0] obs_trap = {t_st, t_pcw, t_adr, t_mw, t_irw, t_rw, t_res, t_a, t_b, t_aop, t_imm, t_ill, t_ret};
  wire [21:0] obs_nop  = {n_st, n_pcw, n_adr, n_mw, n_irw, n_rw, n_res, n_a, n_b, n_aop, n_imm, n_ill, n_ret};

  // One instruction step; fields flagged by wt are qualified by mem_ready.
  typedef struct {
    logic [3:0] st;
    logic adr, mw, irw, rw;
    logic [1:0] res, a, b, aop;
    logic pcu, br, ret, wt;
  } step_t;

  step_t steps[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic step_t mk(input logic [3:0] st, input logic adr, mw, irw, rw,
                               input logic [1:0] res, a, b, aop,
                               input logic pcu, br, ret, wt);
    step_t s;
    s.st = st; s.adr = adr; s.mw = mw; s.irw = irw; s.rw = rw;
    s.res = res; s.a = a; s.b = b; s.aop = aop;
    s.pcu = pcu; s.br = br; s.ret = ret; s.wt = wt;
    return s;
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected step sequence of an instruction, from the per-state action table.
  function automatic void build(input logic [6:0] op);
    steps.delete();
    steps.push_back(mk(S_FETCH,  0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 1,0,0,1));
    steps.push_back(mk(S_DECODE, 0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0,0,0));
    case (op)
      7'b0000011: begin
        steps.push_back(mk(S_MEMADR,  0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0,0));
        steps.push_back(mk(S_MEMREAD, 1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,1));
        steps.push_back(mk(S_MEMWB,   0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 0,0,1,0));
      end
      7'b0100011: begin
        steps.push_back(mk(S_MEMADR,   0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0,0));
        steps.push_back(mk(S_MEMWRITE, 1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1,1));
      end
      7'b0110011: begin
        steps.push_back(mk(S_EXECR, 0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,0,0));
        steps.push_back(mk(S_ALUWB, 0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,1,0));
      end
      7'b0010011: begin
        steps.push_back(mk(S_EXECI, 0,0,0,0, 2'b00,2'b10,2'b01,2'b11, 0,0,0,0));
        steps.push_back(mk(S_ALUWB, 0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,1,0));
      end
      7'b1100011:
        steps.push_back(mk(S_BRANCH, 0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,1,1,0));
      7'b1101111: begin
        steps.push_back(mk(S_JAL,   0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 1,0,0,0));
        steps.push_back(mk(S_ALUWB, 0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,1,0));
      end
      7'b1100111: begin
        steps.push_back(mk(S_JALR,     0,0,0,0, 2'b10,2'b10,2'b01,2'b00, 1,0,0,0));
        steps.push_back(mk(S_JALRLINK, 0,0,0,1, 2'b10,2'b01,2'b10,2'b00, 0,0,1,0));
      end
      7'b0110111:
        steps.push_back(mk(S_LUI, 0,0,0,1, 2'b11,2'b00,2'b00,2'b00, 0,0,1,0));
      default: ;
    endcase
  endfunction

  function automatic logic [21:0] expect_vec(input step_t s, input logic mr, input logic bt, input logic r,
                                              input logic [6:0] op);
    logic g, en;
    g  = s.wt ? mr : 1'b1;
    en = ~r;
    return {s.st, en & ((s.pcu & g) | (s.br & bt)), s.adr, en & s.mw, en & s.irw & g,
            en & s.rw, s.res, s.a, s.b, s.aop, exp_imm(op), 1'b0, en & s.ret & g};
  endfunction

  // waits<0: random stalls (max 4 per step); abort_at>=0: reset in that step.
  task automatic run_instr(input logic [6:0] op, input int waits, input int abort_at, input int exp_lat);
    int i = 0, cyc = 0, lowcnt = 0, retire_at = 0;
    bit done = 0;
    logic [21:0] exp;
    step_t s;
    build(op);
    while (!done) begin
      @(posedge clk); #1;
      rst = 1'b0;
      opcode = op;
      branch_taken = 1'($urandom);
      s = steps[i];
      if (s.wt) mem_ready = (waits < 0) ? ((lowcnt >= 4) ? 1'b1 : 1'($urandom)) : (lowcnt >= waits);
      else      mem_ready = 1'($urandom);
      if (i == abort_at) begin rst = 1'b1; mem_ready = 1'b0; end
      #1;
      exp = expect_vec(s, mem_ready, branch_taken, rst, op);
      check($sformatf("op%b_step%0d_trap", op, i), 32'(obs_trap), 32'(exp));
      check($sformatf("op%b_step%0d_nop", op, i), 32'(obs_nop), 32'(exp));
      cyc++;
      if (t_ret && retire_at == 0) retire_at = cyc;
      if (rst) done = 1;
      else if (!s.wt || mem_ready) begin
        i++;
        lowcnt = 0;
        if (i == steps.size()) done = 1;
      end else lowcnt++;
    end
    if (exp_lat > 0) check($sformatf("latency_op%b", op), 32'(retire_at), 32'(exp_lat));
  endtask

  // FETCH/DECODE of an unknown opcode, then 10 trapped cycles, then reset.
  task automatic run_illegal(input logic [6:0] op);
    logic [21:0] exp_t, exp_n;
    run_instr(op, -1, -1, 0);
    for (int unsigned k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      branch_taken = 1'($urandom);
      #1;
      exp_t = {4'(S_TRAP), 5'b0, 8'b0, exp_imm(op), 1'b1, 1'b0};
      exp_n = {4'(S_FETCH), 5'b0, 2'b10, 2'b00, 2'b10, 2'b00, exp_imm(op), 1'b0, 1'b0};
      check($sformatf("trap_cycle%0d", k), 32'(obs_trap), 32'(exp_t));
      check($sformatf("nop_cycle%0d", k), 32'(obs_nop), 32'(exp_n));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    branch_taken = 1'b1;
    #1;
    check("trap_rst", 32'(obs_trap), 32'({4'(S_TRAP), 5'b0, 8'b0, exp_imm(op), 1'b1, 1'b0}));
    check("nop_rst", 32'(obs_nop), 32'({4'(S_FETCH), 5'b0, 2'b10, 2'b00, 2'b10, 2'b00, exp_imm(op), 2'b00}));
  endtask

  logic [6:0] legal_ops [8];
  int lat_tab [8];

  initial begin
    logic [6:0] op;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    lat_tab   = '{5, 4, 4, 4, 3, 4, 4, 3};
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b1; branch_taken = 1'b1; opcode = 7'b0000011;
    #1;
    check("reset_trap", 32'(obs_trap), 32'({4'(S_FETCH), 5'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00}));
    check("reset_nop", 32'(obs_nop), 32'({4'(S_FETCH), 5'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00}));

    for (int i = 0; i < 8; i++) run_instr(legal_ops[i], 0, -1, lat_tab[i]);
    run_instr(7'b0100011, 3, -1, 0);
    for (int i = 0; i < 6; i++) run_instr(7'b1100011, -1, -1, 0);
    run_illegal(7'b0000000);
    run_instr(7'b0100011, 0, 3, 0);
    run_instr(7'b0000011, 0, -1, 5);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
        run_illegal(op);
      end else if ($urandom_range(0, 9) == 0) begin
        op = legal_ops[$urandom_range(0, 7)];
        build(op);
        run_instr(op, -1, $urandom_range(0, steps.size() - 1), 0);
      end else begin
        run_instr(legal_ops[$urandom_range(0, 7)], -1, -1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
